// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with a single-outstanding-request memory FSM and IF/ID register.
// Optional perf counters (fetch_count, stall_count) are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic [6:0]  opcode_d,
    output logic [2:0]  fun3_d,
    output logic        fun7_d
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DROP = 3'd4;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [2:0]  state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        load;
    logic        ifid_load;
    logic [31:0] load_instr;
    logic [31:0] target;
    logic [31:0] pc_inc;
    logic        unused_tgt_lsb;

    assign target         = {pc_target[31:2], 2'b00};
    assign unused_tgt_lsb = ^pc_target[1:0];
    assign pc_inc         = fpc_q + 32'd4;

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = fpc_q;

    // Fetch FSM: PC, hold buffer and next state; redirect beats stall.
    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        hold_d     = hold_q;
        load       = 1'b0;
        load_instr = imem_rdata;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (pc_src) fpc_d = target;
            end
            S_REQ: begin
                if (pc_src) begin
                    fpc_d   = target;
                    state_d = imem_ready ? S_DROP : S_REQ;
                end else if (imem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (pc_src) begin
                        fpc_d   = target;
                        state_d = S_REQ;
                    end else if (!stall_f) begin
                        load    = 1'b1;
                        fpc_d   = pc_inc;
                        state_d = S_REQ;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (pc_src) begin
                    fpc_d   = target;
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                if (pc_src) begin
                    fpc_d   = target;
                    state_d = S_REQ;
                end else if (!stall_f) begin
                    load       = 1'b1;
                    load_instr = hold_q;
                    fpc_d      = pc_inc;
                    state_d    = S_REQ;
                end
            end
            S_DROP: begin
                // The in-flight response belongs to the abandoned path.
                if (pc_src) fpc_d = target;
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // IF/ID next value: flush, then stall, then load, else bubble.
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        ifid_load    = 1'b0;
        if (flush_d) begin
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
        end else if (stall_f) begin
            ifid_instr_d = ifid_instr_q;
        end else if (load) begin
            ifid_load    = 1'b1;
            ifid_instr_d = load_instr;
            ifid_pc_d    = fpc_q;
            ifid_pc4_d   = pc_inc;
            ifid_valid_d = 1'b1;
        end else begin
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
        end
    end

    // State, PC, hold buffer and IF/ID registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fpc_q        <= RESET_PC;
            hold_q       <= 32'd0;
            ifid_instr_q <= NOP;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fpc_q        <= fpc_d;
            hold_q       <= hold_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign instr_d    = ifid_instr_q;
    assign pc_d       = ifid_pc_q;
    assign pc_plus4_d = ifid_pc4_q;
    assign valid_d    = ifid_valid_q;
    assign opcode_d   = ifid_instr_q[6:0];
    assign fun3_d     = ifid_instr_q[14:12];
    assign fun7_d     = ifid_instr_q[30];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Free-running wrap-around event counters.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, ifid_load};
        stall_cnt_d = stall_cnt_q + {31'd0, stall_f};
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    logic unused_load;
    assign unused_load = ifid_load;
`endif

endmodule
